// File: rtl/mcpu_intc.sv
// mcpu_intc: MMIO-programmable interrupt controller for the core.
// It latches edge/level peripheral interrupts and applies a fixed priority,
// where the lowest index wins. It presents one interrupt at a time on
// int_pending/int_type and holds it until the core pulses int_clear.
// Optional build macro MCPU_INTC_SWINT_EN adds a write-only SWINT register
// at word offset 4.
// Bus handshake: a write is applied on the clock edge where any periph_we bit
// is set, one byte lane per bit. A read strobe periph_re returns registered
// data on periph_data_out on the following cycle. periph_data_out holds its
// value otherwise.
module mcpu_intc #(
  parameter int NUM_SRC = 8
) (
  input  logic               clkrst_core_clk,
  input  logic               clkrst_core_rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [2:0]         periph_addr,
  input  logic               periph_re,
  input  logic [3:0]         periph_we,
  input  logic [31:0]        periph_data_in,
  output logic [31:0]        periph_data_out,
  output logic               int_pending,
  output logic [3:0]         int_type,
  input  logic               int_clear
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // state_q is also visible to software through STATUS bits 9:8
  state_t state_q, state_n;

  logic [NUM_SRC-1:0] pend_q, pend_n;
  logic [NUM_SRC-1:0] enable_q, enable_n;
  logic [NUM_SRC-1:0] edge_q, edge_n;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] wdata, wmask, w1c, rise, edge_chg, sw_set, eligible;
  logic [31:0]        byte_mask, rdata;
  logic               any_we, ack_hit, win_any, load_int, drop_int;
  logic [3:0]         win_idx;

  assign any_we    = |periph_we;
  assign byte_mask = {{8{periph_we[3]}}, {8{periph_we[2]}},
                      {8{periph_we[1]}}, {8{periph_we[0]}}};
  assign wdata     = periph_data_in[NUM_SRC-1:0];
  assign wmask     = byte_mask[NUM_SRC-1:0];

  assign w1c      = (any_we && periph_addr == 3'd0) ? (wdata & wmask) : '0;
  assign enable_n = (any_we && periph_addr == 3'd1) ?
                    ((enable_q & ~wmask) | (wdata & wmask)) : enable_q;
  assign edge_n   = (any_we && periph_addr == 3'd2) ?
                    ((edge_q & ~wmask) | (wdata & wmask)) : edge_q;
  assign edge_chg = edge_n ^ edge_q;
  assign rise     = irq_src & ~irq_prev;
  assign eligible = pend_q & enable_q;
  assign ack_hit  = (state_q == ST_PRESENT) && int_clear;

`ifdef MCPU_INTC_SWINT_EN
  assign sw_set = (any_we && periph_addr == 3'd4) ? (wdata & wmask) : '0;
`else
  assign sw_set = '0;
`endif

  // Next PENDING: edge bits latch rises; level bits track irq_src; sets beat W1C
  always_comb begin
    pend_n = pend_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_q[i]) begin
        if (w1c[i]) pend_n[i] = 1'b0;
        if (rise[i] || sw_set[i]) pend_n[i] = 1'b1;
        // the ack on the presented edge source overrides a same-cycle edge
        if (ack_hit && int_type == 4'(i)) pend_n[i] = 1'b0;
      end else begin
        pend_n[i] = irq_src[i] | sw_set[i];
      end
      if (edge_chg[i]) pend_n[i] = 1'b0;
    end
  end

  // Fixed priority: the lowest eligible index wins
  always_comb begin
    win_any = |eligible;
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = 4'(i);
    end
  end

  // FSM next state plus the load/drop strobes for the presented interrupt
  always_comb begin
    state_n  = state_q;
    load_int = 1'b0;
    drop_int = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          load_int = 1'b1;
          state_n  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (int_clear) begin
          drop_int = 1'b1;
          state_n  = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // FSM register and the held int_pending/int_type outputs
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q     <= ST_IDLE;
      int_pending <= 1'b0;
      int_type    <= '0;
    end else begin
      state_q <= state_n;
      if (load_int) begin
        int_pending <= 1'b1;
        int_type    <= win_idx;
      end else if (drop_int) begin
        int_pending <= 1'b0;
      end
    end
  end

  // Source registers and the edge-detect history
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      pend_q   <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      irq_prev <= '0;
    end else begin
      pend_q   <= pend_n;
      enable_q <= enable_n;
      edge_q   <= edge_n;
      irq_prev <= irq_src;
    end
  end

  // Read mux; unimplemented offsets and bits above NUM_SRC read 0
  always_comb begin
    rdata = '0;
    case (periph_addr)
      3'd0: rdata[NUM_SRC-1:0] = pend_q;
      3'd1: rdata[NUM_SRC-1:0] = enable_q;
      3'd2: rdata[NUM_SRC-1:0] = edge_q;
      3'd3: rdata[9:0] = {state_q, int_type, 3'b000, int_pending};
      default: rdata = '0;
    endcase
  end

  // Registered read data, held while no read is strobed
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) periph_data_out <= '0;
    else if (periph_re)  periph_data_out <= rdata;
  end

endmodule
